// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundles are packed in the order the top drives its output ports.
package hazard_controller_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hazard_state_type;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_stall;
  } hazard_ctrl_type;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam hazard_ctrl_type CTRL_NONE   = hazard_ctrl_type'(5'b00000);
  localparam hazard_ctrl_type CTRL_FREEZE = hazard_ctrl_type'(5'b11001);
  localparam hazard_ctrl_type CTRL_BUBBLE = hazard_ctrl_type'(5'b11010);
  localparam hazard_ctrl_type CTRL_FLUSH  = hazard_ctrl_type'(5'b00110);

endpackage

// File: rtl/hazard_controller_load_use_detector.sv
// Flags a decode instruction that reads the destination of a load sitting in execute.
// x0 is never a real dependency, so a load targeting it is ignored.
module load_use_detector
  import hazard_controller_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hit
);

  logic rs1_match;
  logic rs2_match;

  always_comb begin
    rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    hit       = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, taken-branch flushes,
// multi-cycle MDU waits with a watchdog, memory freezes, and a stall-cycle perf counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MDU_TIMEOUT = 40,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mdu_start,
  input  logic                 mdu_done,
  input  logic                 mem_stall,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_stall,
  output logic                 mdu_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output hazard_state_type     dbg_state
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  hazard_state_type     state_q, state_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 mdu_timeout_q, mdu_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  hazard_ctrl_type      ctrl;
  hazard_ctrl_type      ctrl_out;
  logic                 load_use_hit;

  load_use_detector u_load_use_detector (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hit         (load_use_hit)
  );

  // Priority: memory freeze, then branch flush, then MDU entry, then load-use bubble.
  always_comb begin
    ctrl          = CTRL_NONE;
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    mdu_timeout_d = mdu_timeout_q;
    if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else if (state_q == RUN) begin
      if (ex_branch_taken) begin
        ctrl = CTRL_FLUSH;
      end else if (ex_mdu_start && !mdu_done) begin
        ctrl     = CTRL_FREEZE;
        state_d  = MDU_WAIT;
        wd_cnt_d = WD_ONE;
      end else if (load_use_hit) begin
        ctrl = CTRL_BUBBLE;
      end
    end else if (!mdu_done) begin
      ctrl = CTRL_FREEZE;
      if (wd_cnt_q == WD_LAST) begin
        mdu_timeout_d = 1'b1;
        state_d       = RUN;
        wd_cnt_d      = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_ONE;
      end
    end else begin
      state_d  = RUN;
      wd_cnt_d = '0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (ctrl.pc_stall && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    ctrl_out = reset_n ? ctrl : CTRL_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      wd_cnt_q       <= '0;
      mdu_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wd_cnt_q       <= wd_cnt_d;
      mdu_timeout_q  <= mdu_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pc_stall     = ctrl_out.pc_stall;
  assign if_id_stall  = ctrl_out.if_id_stall;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_stall     = ctrl_out.ex_stall;
  assign mdu_timeout  = mdu_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller with a queue-based scoreboard.
// A second instance with a 2-bit counter exercises perf-counter saturation.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  localparam int W = 41;
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] LU = 5'b11010;
  localparam logic [4:0] ST = 5'b11001;
  localparam logic [4:0] BR = 5'b00110;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic ex_mdu_start, mdu_done, mem_stall;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall, mdu_timeout;
  logic [31:0] stall_cycles;
  hazard_state_type dbg_state;
  logic s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush, s_ex_stall, s_mdu_timeout;
  logic [1:0] s_stall_cycles;
  hazard_state_type s_dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  hazard_controller #(.MDU_TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_stall(mem_stall), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_stall(ex_stall), .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles),
    .dbg_state(dbg_state)
  );

  hazard_controller #(.MDU_TIMEOUT(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_stall(mem_stall), .pc_stall(s_pc_stall),
    .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_stall(s_ex_stall), .mdu_timeout(s_mdu_timeout), .stall_cycles(s_stall_cycles),
    .dbg_state(s_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall,
             mdu_timeout, dbg_state, stall_cycles, s_stall_cycles};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got ctrl=%b to=%b st=%b cnt=%0d sat=%0d, want ctrl=%b to=%b st=%b cnt=%0d sat=%0d",
                 nm, act[40:36], act[35], act[34], act[33:2], act[1:0],
                 exp[40:36], exp[35], exp[34], exp[33:2], exp[1:0]);
      end
    end
    checks++;
    if (id_ex_flush && ex_stall) begin
      errors++;
      $display("FAIL flush_stall_excl: got id_ex_flush=1 ex_stall=1, want not both");
    end
  end

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0; mem_stall = 1'b0;
  endtask

  // Driver: push expectation for the current cycle, then advance one clock.
  task automatic drive(input logic [4:0] ctrl_e, input logic st_e, input logic to_e,
                       input string nm);
    logic [31:0] c;
    logic [1:0]  s;
    if (!reset_n) cnt_model = 0;
    c = 32'(cnt_model);
    s = (cnt_model > 3) ? 2'd3 : 2'(cnt_model);
    exp_q.push_back({ctrl_e, to_e, st_e, c, s});
    name_q.push_back(nm);
    if (reset_n && ctrl_e[4]) cnt_model++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hit();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    set_hit();
    @(posedge clk);
    #1;
    drive(Z, 1'b0, 1'b0, "rst_gate");
    drive(Z, 1'b0, 1'b0, "rst_gate2");
    reset_n = 1'b1;
    clr();
    drive(Z, 1'b0, 1'b0, "idle");

    set_hit();
    drive(LU, 1'b0, 1'b0, "lu_rs1");
    clr();
    drive(Z, 1'b0, 1'b0, "after_lu");
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    drive(Z, 1'b0, 1'b0, "rd_zero");
    ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
    drive(Z, 1'b0, 1'b0, "rs1_unused");
    id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
    drive(LU, 1'b0, 1'b0, "lu_rs2");
    id_rs2 = 5'd6;
    drive(Z, 1'b0, 1'b0, "rs2_miss");
    id_rs2 = 5'd5; ex_mem_read = 1'b0;
    drive(Z, 1'b0, 1'b0, "not_load");
    ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
    drive(BR, 1'b0, 1'b0, "br_beats_lu");
    clr();

    mem_stall = 1'b1; ex_branch_taken = 1'b1;
    drive(ST, 1'b0, 1'b0, "mem_over_br");
    mem_stall = 1'b0;
    drive(BR, 1'b0, 1'b0, "br_after_mem");
    clr();

    ex_mdu_start = 1'b1; mdu_done = 1'b1;
    drive(Z, 1'b0, 1'b0, "mdu_1cyc");
    clr();

    ex_mdu_start = 1'b1;
    drive(ST, 1'b0, 1'b0, "mdu_enter");
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) set_hit();
      else begin ex_mem_read = 1'b0; id_uses_rs1 = 1'b0; end
      drive(ST, 1'b1, 1'b0, "mdu_wait");
    end
    mdu_done = 1'b1;
    drive(Z, 1'b1, 1'b0, "mdu_done");
    clr();
    drive(Z, 1'b0, 1'b0, "mdu_exit");

    ex_mdu_start = 1'b1;
    drive(ST, 1'b0, 1'b0, "wd_enter");
    for (int i = 1; i <= 7; i++) drive(ST, 1'b1, 1'b0, "wd_wait");
    ex_mdu_start = 1'b0;
    drive(Z, 1'b0, 1'b1, "wd_resume");
    drive(Z, 1'b0, 1'b1, "to_sticky");

    ex_mdu_start = 1'b1;
    drive(ST, 1'b0, 1'b1, "mw_enter");
    drive(ST, 1'b1, 1'b1, "mw_wait");
    mem_stall = 1'b1;
    drive(ST, 1'b1, 1'b1, "mw_mem1");
    mdu_done = 1'b1;
    drive(ST, 1'b1, 1'b1, "mem_done_ignored");
    mdu_done = 1'b0;
    drive(ST, 1'b1, 1'b1, "mw_mem3");
    mem_stall = 1'b0;
    drive(ST, 1'b1, 1'b1, "still_wait");
    reset_n = 1'b0;
    drive(Z, 1'b0, 1'b0, "async_rst");
    reset_n = 1'b1;
    ex_mdu_start = 1'b0;
    drive(Z, 1'b0, 1'b0, "post_rst");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
